display_scan_ctrl: RTL and testbench
====================================

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk is the only clock, and rst resets all state immediately without waiting for a clock edge.
REQ-002 The block SHALL have parameter DIV, default 50000, giving the clk cycles per digit slot (legal range 2 to 2^20).
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 value  input  16  four hex digits; [3:0] is digit 0 (least significant) and [15:12] is digit 3.
REQ-006 load  input  1  update request; the requester holds it high until ack.
REQ-007 ack  output  1  one-cycle pulse confirming the new value is now displayed.
REQ-008 nibble  output  4  code of the active digit, sent to the shared 4-bit-to-7-segment decoder.
REQ-009 an  output  4  digit enables, active-low and one-hot; 4'b1111 means the slot is blanked.
REQ-010 frame_tick  output  1  one-cycle pulse at the end of each 4-digit frame.

Function
REQ-011 The block SHALL contain a slot counter cnt running 0..DIV-1; at cnt==DIV-1 it returns to 0 and the digit index idx advances 0->1->2->3->0.
REQ-012 nibble SHALL equal shadow[4*idx+3:4*idx], and an SHALL equal ~(4'b0001<<idx) unless the slot is blanked per REQ-022; both are decoded from flops only, so the displayed digit changes in the cycle after the slot boundary.
REQ-013 frame_tick SHALL be high for exactly the one cycle after the edge where idx wraps 3->0, giving one pulse every 4*DIV cycles.
REQ-014 The FSM SHALL have three states: SCAN, PEND and ACK.
REQ-015 In SCAN, if load is sampled high, the block SHALL capture value into a staging register and move to PEND.
REQ-016 In PEND, at the edge where idx==3 and cnt==DIV-1 (frame end), the block SHALL copy staging into shadow and move to ACK.
REQ-017 In ACK, ack SHALL be 1 for that single cycle, and the FSM SHALL then return to SCAN.
REQ-018 The shadow register SHALL change only at a frame end, so no frame ever shows a mix of old and new digits.
REQ-019 Boundary -- simultaneous events: if load is captured in SCAN on the same edge as a frame end, the commit SHALL happen at the next frame end, 4*DIV cycles later, not at the current one.
REQ-020 Boundary -- load during PEND or ACK SHALL be ignored and the staging register SHALL keep its value; if load is still high when the FSM re-enters SCAN, it SHALL start a new request.
REQ-021 Boundary -- loading a value equal to the current shadow SHALL still run the full handshake and produce ack.

Reset
REQ-022 While rst is high, the block SHALL hold: cnt=0, idx=0, state=SCAN, shadow=16'h0000, staging=16'h0000, an=4'b1110, nibble=4'h0, ack=0, frame_tick=0.
REQ-023 A reset during PEND or ACK SHALL discard the pending request with no ack issued, and shadow SHALL be 16'h0000 afterwards.
REQ-024 Scanning SHALL restart from digit 0 on the first clk edge after rst is released.

Configuration
REQ-025 With macro LEAD_ZERO_BLANK_EN defined, the slot for digit k (k>=1) SHALL have an=4'b1111 whenever shadow nibbles k through 3 are all zero.
REQ-026 Digit 0 SHALL never be blanked, so a value of 0 displays a single "0".
REQ-027 With LEAD_ZERO_BLANK_EN undefined, no slot SHALL ever be blanked, and an SHALL always be one-hot active-low.

Verification (DIV=4)
REQ-028 Release rst -> an=1110 and nibble=0 for 4 cycles, then an=1101, 1011, 0111, and frame_tick pulses every 16 cycles.
REQ-029 Hold load with value=16'h1A3F from SCAN -> ack is high for one cycle right after the next frame end, and the next frame shows nibble F,3,A,1 on an 1110,1101,1011,0111.
REQ-030 Assert load in the frame-end cycle -> ack arrives 17 cycles later, and the old digits are shown throughout the intervening frame.
REQ-031 Pulse rst while in PEND after loading 16'h1234 -> ack is never seen, and all slots show nibble 0.
REQ-032 LEAD_ZERO_BLANK_EN defined, load 16'h0050 -> slots 2 and 3 show an=1111, and slots 0 and 1 show 0 and 5; with the macro undefined, all four slots are enabled.
REQ-033 Hold load high across ack -> a second request is captured in the cycle after ACK, and a second ack follows the next frame end.

Source files
------------

// File: rtl/display_scan_ctrl_if.sv
// Requester/display bundle for display_scan_ctrl: value/load/ack handshake plus scan outputs.
// Handshake: the requester raises load with value and holds both until ack, a one-cycle pulse.
interface display_scan_ctrl_if;
    logic [15:0] value;
    logic        load;
    logic        ack;
    logic [3:0]  nibble;
    logic [3:0]  an;
    logic        frame_tick;

    modport master (
        output value,
        output load,
        input  ack,
        input  nibble,
        input  an,
        input  frame_tick
    );

    modport slave (
        input  value,
        input  load,
        output ack,
        output nibble,
        output an,
        output frame_tick
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed hex display scanner with frame-aligned value updates.
// Optional macro LEAD_ZERO_BLANK_EN blanks leading zero digits (digit 0 is never blanked).
module display_scan_ctrl #(
    parameter int unsigned DIV = 50000
) (
    input  logic                 clk,
    input  logic                 rst,
    display_scan_ctrl_if.slave   bus,
    output logic [1:0]           state_o
);

    localparam int unsigned     CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(DIV - 1);

    typedef enum logic [1:0] {
        SCAN = 2'd0,
        PEND = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [15:0]   staging_q, staging_d;
    logic          tick_q, tick_d;

    logic          slot_end;
    logic          frame_end;
    logic          blank;
    logic [3:0]    nibble_sel;

    // Slot timing: cnt counts clk cycles within a slot, idx selects the digit.
    always_comb begin
        slot_end  = (cnt_q == CNT_MAX);
        frame_end = slot_end && (idx_q == 2'd3);
        cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
        idx_d     = slot_end ? idx_q + 2'd1 : idx_q;
        tick_d    = frame_end;
    end

    always_comb begin
        state_d   = state_q;
        staging_d = staging_q;
        shadow_d  = shadow_q;
        case (state_q)
            SCAN: begin
                if (bus.load) begin
                    staging_d = bus.value;
                    state_d   = PEND;
                end
            end
            PEND: begin
                // Commit only on a frame boundary so a frame never mixes old and new digits.
                if (frame_end) begin
                    shadow_d = staging_q;
                    state_d  = ACK;
                end
            end
            ACK: begin
                state_d = SCAN;
            end
            default: begin
                state_d = SCAN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= SCAN;
            cnt_q     <= '0;
            idx_q     <= 2'd0;
            shadow_q  <= 16'h0000;
            staging_q <= 16'h0000;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            staging_q <= staging_d;
            tick_q    <= tick_d;
        end
    end

    always_comb begin
        nibble_sel = 4'h0;
        case (idx_q)
            2'd0:    nibble_sel = shadow_q[3:0];
            2'd1:    nibble_sel = shadow_q[7:4];
            2'd2:    nibble_sel = shadow_q[11:8];
            default: nibble_sel = shadow_q[15:12];
        endcase
    end

`ifdef LEAD_ZERO_BLANK_EN
    // A slot is blank when its digit and every more significant digit are zero.
    always_comb begin
        blank = 1'b0;
        case (idx_q)
            2'd1:    blank = (shadow_q[15:4]  == 12'h000);
            2'd2:    blank = (shadow_q[15:8]  == 8'h00);
            2'd3:    blank = (shadow_q[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    assign bus.nibble     = nibble_sel;
    assign bus.an         = blank ? 4'b1111 : ~(4'b0001 << idx_q);
    assign bus.ack        = (state_q == ACK);
    assign bus.frame_tick = tick_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed, table-driven bench for display_scan_ctrl with DIV=4 (16-cycle frames).
module tb_display_scan_ctrl;

  localparam int DIV = 4;
  localparam int NTBL = 66;

  typedef struct {
    logic        load;
    logic [15:0] value;
    logic [3:0]  exp_an;
    logic [3:0]  exp_nibble;
    logic        exp_tick;
    logic        exp_ack;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [1:0] state_o;
  int         errors;
  int         checks;
  vec_t       tbl[NTBL];

  display_scan_ctrl_if bus();

  display_scan_ctrl #(.DIV(DIV)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_an_f(input int idx, input logic [15:0] sh);
    logic [3:0] a;
    a = ~(4'b0001 << idx);
`ifdef LEAD_ZERO_BLANK_EN
    if (idx >= 1 && (sh >> (4 * idx)) == 16'h0000) a = 4'b1111;
`endif
    return a;
  endfunction

  // Expected outputs for cycle k after reset release, given the displayed value sh.
  function automatic vec_t mk(input int k, input logic ld, input logic [15:0] val,
                              input logic [15:0] sh, input logic ak);
    vec_t v;
    int idx;
    idx = (k / 4) % 4;
    v.load       = ld;
    v.value      = val;
    v.exp_an     = exp_an_f(idx, sh);
    v.exp_nibble = sh[4*idx +: 4];
    v.exp_tick   = (k > 0) && (k % 16 == 0);
    v.exp_ack    = ak;
    return v;
  endfunction

  task automatic apply(input vec_t v, input int k, input string tag);
    chk($sformatf("%s k=%0d an", tag, k), {12'h0, bus.an}, {12'h0, v.exp_an});
    chk($sformatf("%s k=%0d nibble", tag, k), {12'h0, bus.nibble}, {12'h0, v.exp_nibble});
    chk($sformatf("%s k=%0d frame_tick", tag, k), {15'h0, bus.frame_tick}, {15'h0, v.exp_tick});
    chk($sformatf("%s k=%0d ack", tag, k), {15'h0, bus.ack}, {15'h0, v.exp_ack});
    bus.load  = v.load;
    bus.value = v.value;
    @(negedge clk);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " an"}, {12'h0, bus.an}, 16'h000E);
    chk({tag, " nibble"}, {12'h0, bus.nibble}, 16'h0000);
    chk({tag, " ack"}, {15'h0, bus.ack}, 16'h0000);
    chk({tag, " frame_tick"}, {15'h0, bus.frame_tick}, 16'h0000);
    chk({tag, " state"}, {14'h0, state_o}, 16'h0000);
  endtask

  // Asserts rst at a falling edge, checks it took effect without a clock edge,
  // then releases at a later falling edge; the caller continues at cycle 0.
  task automatic do_reset(input string tag);
    bus.load  = 1'b0;
    bus.value = 16'h0000;
    rst = 1'b1;
    #1;
    chk_reset_state({tag, " async"});
    @(negedge clk);
    @(negedge clk);
    chk_reset_state({tag, " held"});
    rst = 1'b0;
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    bus.load  = 1'b0;
    bus.value = 16'h0000;

    // Main table: scan after reset, load 1A3F, then reload the same value.
    for (int k = 0; k < NTBL; k++) begin
      logic        ld;
      logic [15:0] sh;
      ld = (k >= 20 && k <= 32) || (k >= 50 && k <= 64);
      sh = (k >= 32) ? 16'h1A3F : 16'h0000;
      tbl[k] = mk(k, ld, ld ? 16'h1A3F : 16'h0000, sh, (k == 32) || (k == 64));
    end

    repeat (3) @(negedge clk);
    do_reset("init");
    for (int k = 0; k < NTBL; k++) begin
      if (k == 21) chk("tbl state pend", {14'h0, state_o}, 16'h0001);
      apply(tbl[k], k, "tbl");
    end

    // Load presented in the frame-end cycle commits one full frame later.
    do_reset("sim");
    for (int k = 0; k <= 52; k++) begin
      logic        ld;
      logic [15:0] sh;
      ld = (k <= 16) || (k >= 31 && k <= 48);
      sh = (k < 16) ? 16'h0000 : ((k < 48) ? 16'hBEEF : 16'h5555);
      apply(mk(k, ld, (k <= 16) ? 16'hBEEF : 16'h5555, sh, (k == 16) || (k == 48)), k, "sim");
    end

    // Reset while pending discards the request.
    do_reset("rpend");
    for (int k = 0; k <= 5; k++) begin
      apply(mk(k, k >= 2, 16'h1234, 16'h0000, 1'b0), k, "rpend");
    end
    chk("rpend state pend", {14'h0, state_o}, 16'h0001);
    do_reset("rpulse");
    for (int k = 0; k <= 20; k++) begin
      apply(mk(k, 1'b0, 16'h0000, 16'h0000, 1'b0), k, "rpost");
    end

    // Load held across ack starts a second request; value changes while pending are ignored.
    do_reset("hold");
    for (int k = 0; k <= 35; k++) begin
      logic [15:0] val;
      logic [15:0] sh;
      val = (k == 0) ? 16'h0050 : ((k <= 16) ? 16'hFFFF : 16'h0B02);
      sh  = (k < 16) ? 16'h0000 : ((k < 32) ? 16'h0050 : 16'h0B02);
      if (k == 17) chk("hold state scan", {14'h0, state_o}, 16'h0000);
      if (k == 18) chk("hold state pend", {14'h0, state_o}, 16'h0001);
      apply(mk(k, k <= 32, val, sh, (k == 16) || (k == 32)), k, "hold");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
